// File: rtl/mac_array_atom_if.sv
// mac_array_atom_if: packet-operation bus for mac_array_atom.
//   master modport (packet source): drives i__* operands, receives o__* results.
//   slave modport  (atom):          receives i__* operands, drives o__* results.
//   i__valid/i__index/i__constant/i__pkt_1..3/i__sel1..3 : one operation per cycle
//   o__valid/o__index/o__read/o__write                   : result, 3 edges later
interface mac_array_atom_if #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned IDX_WIDTH   = 4
);

  logic                   i__valid;
  logic [IDX_WIDTH-1:0]   i__index;
  logic [COUNT_WIDTH-1:0] i__constant;
  logic [COUNT_WIDTH-1:0] i__pkt_1;
  logic [COUNT_WIDTH-1:0] i__pkt_2;
  logic [COUNT_WIDTH-1:0] i__pkt_3;
  logic                   i__sel1;
  logic                   i__sel2;
  logic                   i__sel3;

  logic                   o__valid;
  logic [IDX_WIDTH-1:0]   o__index;
  logic [COUNT_WIDTH-1:0] o__read;
  logic [COUNT_WIDTH-1:0] o__write;

  modport master (
    output i__valid, i__index, i__constant, i__pkt_1, i__pkt_2, i__pkt_3,
           i__sel1, i__sel2, i__sel3,
    input  o__valid, o__index, o__read, o__write
  );

  modport slave (
    input  i__valid, i__index, i__constant, i__pkt_1, i__pkt_2, i__pkt_3,
           i__sel1, i__sel2, i__sel3,
    output o__valid, o__index, o__read, o__write
  );

endinterface

// File: rtl/mac_array_atom.sv
// mac_array_atom: 3-stage multiply-accumulate stateful atom over NUM_SLOTS
// independent state registers.
//   write = (sel1 ? 0 : state[idx]) * (sel2 ? pkt_1 : constant)
//           + (sel3 ? pkt_3 : pkt_2)
// Stage 0 captures the operation, stage 1 reads the slot and multiplies,
// stage 2 adds and writes back. A stage-1 read of the slot being written by
// stage 2 in the same cycle takes the forwarded sum instead of the array.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (clears slots, valids and outputs)
//   bus   : mac_array_atom_if.slave (operation in, result out)
// Optional feature macro: MAC_ATOM_SATURATE_EN
//   defined   -> multiply and add clamp to 2^COUNT_WIDTH-1 on overflow
//   undefined -> multiply and add wrap modulo 2^COUNT_WIDTH
module mac_array_atom #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned NUM_SLOTS   = 16,
  parameter int unsigned IDX_WIDTH   = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  mac_array_atom_if.slave   bus
);

  localparam int unsigned W  = COUNT_WIDTH;
  localparam int unsigned IW = IDX_WIDTH;

  // Slot storage
  logic [W-1:0]  state [NUM_SLOTS];

  // Stage 0: captured operation
  logic          s0_valid;
  logic [IW-1:0] s0_idx;
  logic [W-1:0]  s0_constant;
  logic [W-1:0]  s0_pkt_1;
  logic [W-1:0]  s0_pkt_2;
  logic [W-1:0]  s0_pkt_3;
  logic          s0_sel1;
  logic          s0_sel2;
  logic          s0_sel3;

  // Stage 1: product and operands carried to the adder
  logic          s1_valid;
  logic [IW-1:0] s1_idx;
  logic [W-1:0]  s1_prod;
  logic [W-1:0]  s1_c;
  logic [W-1:0]  s1_old;

  // Combinational datapath
  logic          idx_ok;
  logic          fwd;
  logic [W-1:0]  old;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  op_c;
  logic [W-1:0]  prod;
  logic [W-1:0]  sum;

  // Out-of-range indices only exist when NUM_SLOTS is not a power of two
  if ((1 << IW) > NUM_SLOTS) begin : g_partial_idx
    assign idx_ok = (32'(bus.i__index) < NUM_SLOTS);
  end else begin : g_full_idx
    assign idx_ok = 1'b1;
  end

  // Stage 2 add; this is also the forwarded value so both paths agree
`ifdef MAC_ATOM_SATURATE_EN
  logic [W:0] sum_full;
  always_comb begin
    sum_full = {1'b0, s1_prod} + {1'b0, s1_c};
    sum      = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
  end
`else
  always_comb begin
    sum = s1_prod + s1_c;
  end
`endif

  // Stage 1 read with forwarding from the in-flight stage-2 write
  always_comb begin
    fwd  = s1_valid && (s1_idx == s0_idx);
    old  = fwd ? sum : state[s0_idx];
    op_a = s0_sel1 ? '0 : old;
    op_b = s0_sel2 ? s0_pkt_1 : s0_constant;
    op_c = s0_sel3 ? s0_pkt_3 : s0_pkt_2;
  end

  // Stage 1 multiply
`ifdef MAC_ATOM_SATURATE_EN
  logic [2*W-1:0] prod_full;
  always_comb begin
    prod_full = {W'(0), op_a} * {W'(0), op_b};
    prod      = (|prod_full[2*W-1:W]) ? {W{1'b1}} : prod_full[W-1:0];
  end
`else
  always_comb begin
    prod = op_a * op_b;
  end
`endif

  // Pipeline registers, slot write-back and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        state[i] <= '0;
      end
      s0_valid     <= 1'b0;
      s0_idx       <= '0;
      s0_constant  <= '0;
      s0_pkt_1     <= '0;
      s0_pkt_2     <= '0;
      s0_pkt_3     <= '0;
      s0_sel1      <= 1'b0;
      s0_sel2      <= 1'b0;
      s0_sel3      <= 1'b0;
      s1_valid     <= 1'b0;
      s1_idx       <= '0;
      s1_prod      <= '0;
      s1_c         <= '0;
      s1_old       <= '0;
      bus.o__valid <= 1'b0;
      bus.o__index <= '0;
      bus.o__read  <= '0;
      bus.o__write <= '0;
    end else begin
      // Out-of-range index enters the pipe as a bubble
      s0_valid    <= bus.i__valid && idx_ok;
      s0_idx      <= bus.i__index;
      s0_constant <= bus.i__constant;
      s0_pkt_1    <= bus.i__pkt_1;
      s0_pkt_2    <= bus.i__pkt_2;
      s0_pkt_3    <= bus.i__pkt_3;
      s0_sel1     <= bus.i__sel1;
      s0_sel2     <= bus.i__sel2;
      s0_sel3     <= bus.i__sel3;

      s1_valid    <= s0_valid;
      s1_idx      <= s0_idx;
      s1_prod     <= prod;
      s1_c        <= op_c;
      s1_old      <= old;

      bus.o__valid <= s1_valid;
      if (s1_valid) begin
        state[s1_idx] <= sum;
        bus.o__index  <= s1_idx;
        bus.o__read   <= s1_old;
        bus.o__write  <= sum;
      end
    end
  end

endmodule

// File: tb/tb_mac_array_atom.sv
// Testbench for mac_array_atom: directed vector table with hand-computed
// results, a reset-mid-flight sequence, then random traffic, all compared
// against a serial reference model delayed to the atom's output latency.
module tb_mac_array_atom;

  localparam int unsigned W  = 32;
  localparam int unsigned NS = 16;
  localparam int unsigned IW = 4;
  localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

  typedef struct {
    bit          valid;
    logic [3:0]  idx;
    logic [31:0] constant;
    logic [31:0] pkt_1;
    logic [31:0] pkt_2;
    logic [31:0] pkt_3;
    bit          sel1;
    bit          sel2;
    bit          sel3;
    bit          has_exp;
    logic [31:0] exp_read;
    logic [31:0] exp_write;
  } op_t;

  typedef struct {
    bit          valid;
    logic [3:0]  idx;
    logic [31:0] rd;
    logic [31:0] wr;
    bit          has_exp;
    logic [31:0] exp_read;
    logic [31:0] exp_write;
    int          tag;
  } res_t;

  logic clk;
  logic rst_n;

  mac_array_atom_if #(.COUNT_WIDTH(W), .IDX_WIDTH(IW)) bus ();

  mac_array_atom #(.COUNT_WIDTH(W), .NUM_SLOTS(NS), .IDX_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int tag_cnt;

  // Reference model: serial slot array plus a two-deep result delay line
  logic [31:0] mstate [NS];
  res_t        pipe [2];
  res_t        vis;

  function automatic op_t mk(input bit v, input int idx, input logic [31:0] c,
                             input logic [31:0] p1, input logic [31:0] p2,
                             input logic [31:0] p3, input bit s1, input bit s2,
                             input bit s3, input bit he, input logic [31:0] er,
                             input logic [31:0] ew);
    op_t o;
    o.valid = v; o.idx = 4'(idx); o.constant = c;
    o.pkt_1 = p1; o.pkt_2 = p2; o.pkt_3 = p3;
    o.sel1 = s1; o.sel2 = s2; o.sel3 = s3;
    o.has_exp = he; o.exp_read = er; o.exp_write = ew;
    return o;
  endfunction

  function automatic op_t bubble();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [31:0] mac(input logic [31:0] old_v, input op_t o);
    longint unsigned a, b, c, p, s;
    a = o.sel1 ? 64'd0 : 64'(old_v);
    b = o.sel2 ? 64'(o.pkt_1) : 64'(o.constant);
    c = o.sel3 ? 64'(o.pkt_3) : 64'(o.pkt_2);
    p = a * b;
`ifdef MAC_ATOM_SATURATE_EN
    if (p > MAXV) p = MAXV;
`else
    p = p & MAXV;
`endif
    s = p + c;
`ifdef MAC_ATOM_SATURATE_EN
    if (s > MAXV) s = MAXV;
`else
    s = s & MAXV;
`endif
    return 32'(s);
  endfunction

  task automatic chk(input string name, input int tag, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (op %0d) at %0t: got %0h expected %0h", name, tag, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NS); i++) mstate[i] = '0;
    pipe[0] = '{default: 0};
    pipe[1] = '{default: 0};
    vis     = '{default: 0};
  endtask

  // One clock: drive, let the edge happen, advance model, check on negedge
  task automatic cycle(input op_t o);
    res_t r;
    bus.i__valid    = o.valid;
    bus.i__index    = o.idx;
    bus.i__constant = o.constant;
    bus.i__pkt_1    = o.pkt_1;
    bus.i__pkt_2    = o.pkt_2;
    bus.i__pkt_3    = o.pkt_3;
    bus.i__sel1     = o.sel1;
    bus.i__sel2     = o.sel2;
    bus.i__sel3     = o.sel3;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (pipe[1].valid) vis = pipe[1];
      else               vis.valid = 1'b0;
      pipe[1] = pipe[0];
      r = '{default: 0};
      if (o.valid) begin
        tag_cnt++;
        r.valid     = 1'b1;
        r.idx       = o.idx;
        r.rd        = mstate[o.idx];
        r.wr        = mac(mstate[o.idx], o);
        r.has_exp   = o.has_exp;
        r.exp_read  = o.exp_read;
        r.exp_write = o.exp_write;
        r.tag       = tag_cnt;
        mstate[o.idx] = r.wr;
      end
      pipe[0] = r;
    end
    @(negedge clk);
    chk("o_valid", vis.tag, 64'(bus.o__valid), 64'(vis.valid));
    chk("o_index", vis.tag, 64'(bus.o__index), 64'(vis.idx));
    chk("o_read",  vis.tag, 64'(bus.o__read),  64'(vis.rd));
    chk("o_write", vis.tag, 64'(bus.o__write), 64'(vis.wr));
    if (vis.valid && vis.has_exp) begin
      chk("vec_read",  vis.tag, 64'(bus.o__read),  64'(vis.exp_read));
      chk("vec_write", vis.tag, 64'(bus.o__write), 64'(vis.exp_write));
      vis.has_exp = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    int unsigned k;
    k = $urandom_range(0, 3);
    case (k)
      0:       return 32'($urandom_range(0, 15));
      1:       return 32'($urandom);
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
      default: return 32'($urandom_range(0, 3));
    endcase
  endfunction

  op_t vecs[$];
  logic [31:0] ovf_exp;

  initial begin
    checks  = 0;
    errors  = 0;
    tag_cnt = 0;
`ifdef MAC_ATOM_SATURATE_EN
    ovf_exp = 32'hFFFF_FFFF;
`else
    ovf_exp = 32'h0000_0001;
`endif

    // valid, idx, constant, pkt_1, pkt_2, pkt_3, sel1, sel2, sel3, has_exp, read, write
    vecs.push_back(mk(1, 3, 5, 0, 7, 0, 0, 0, 0, 1, 0, 7));
    vecs.push_back(bubble());
    vecs.push_back(mk(1, 2, 2, 0, 1, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 2, 2, 0, 1, 0, 0, 0, 0, 1, 1, 3));
    vecs.push_back(mk(1, 2, 2, 0, 1, 0, 0, 0, 0, 1, 3, 7));
    vecs.push_back(mk(1, 2, 2, 0, 1, 0, 0, 0, 0, 1, 7, 15));
    vecs.push_back(mk(1, 0, 1, 0, 10, 0, 0, 0, 0, 1, 0, 10));
    vecs.push_back(mk(1, 1, 1, 0, 20, 0, 0, 0, 0, 1, 0, 20));
    vecs.push_back(mk(1, 0, 1, 0, 10, 0, 0, 0, 0, 1, 10, 20));
    vecs.push_back(mk(1, 1, 1, 0, 20, 0, 0, 0, 0, 1, 20, 40));
    vecs.push_back(mk(1, 0, 1, 0, 10, 0, 0, 0, 0, 1, 20, 30));
    vecs.push_back(mk(1, 1, 1, 0, 20, 0, 0, 0, 0, 1, 40, 60));
    vecs.push_back(mk(1, 5, 0, 0, 100, 0, 1, 0, 0, 1, 0, 100));
    vecs.push_back(mk(1, 5, 3, 0, 4, 9, 1, 0, 1, 1, 100, 9));
    vecs.push_back(mk(1, 6, 0, 3, 0, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 6, 0, 3, 4, 0, 0, 1, 0, 1, 0, 4));
    vecs.push_back(bubble());
    vecs.push_back(mk(1, 6, 0, 3, 1, 0, 0, 1, 0, 1, 4, 13));
    vecs.push_back(mk(1, 7, 0, 0, 32'hFFFF_FFFF, 0, 1, 0, 0, 1, 0, 32'hFFFF_FFFF));
    vecs.push_back(mk(1, 7, 1, 0, 2, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, ovf_exp));
    vecs.push_back(bubble());
    vecs.push_back(bubble());
    vecs.push_back(bubble());

    // Reset: outputs and model both cleared
    rst_n = 1'b0;
    model_reset();
    cycle(bubble());
    cycle(bubble());
    chk("reset_o_valid", 0, 64'(bus.o__valid), 64'd0);
    chk("reset_o_write", 0, 64'(bus.o__write), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) cycle(vecs[i]);

    // Reset while two operations on slot 9 are in flight
    cycle(mk(1, 9, 0, 0, 50, 0, 1, 0, 0, 0, 0, 0));
    cycle(mk(1, 9, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    cycle(bubble());
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(bubble());
      chk("midrst_no_valid", i, 64'(bus.o__valid), 64'd0);
    end
    cycle(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    cycle(bubble());
    cycle(bubble());
    chk("midrst_valid_after", 0, 64'(bus.o__valid), 64'd1);
    chk("midrst_read_zero", 0, 64'(bus.o__read), 64'd0);

    // Random traffic concentrated on few slots to stress forwarding
    for (int n = 0; n < 3000; n++) begin
      op_t o;
      rst_n = ($urandom_range(0, 299) != 0);
      o = mk(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
             pick(), pick(), pick(), pick(),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 1) != 0,
             $urandom_range(0, 1) != 0, 0, 0, 0);
      cycle(o);
    end
    rst_n = 1'b1;
    cycle(bubble());
    cycle(bubble());
    cycle(bubble());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_array_atom.md
# mac_array_atom

Pipelined, parametrised multiply-accumulate stateful atom for the packet-transaction datapath. Holds `NUM_SLOTS` independent state registers instead of one, selected per packet by an index, and computes `write = mux(state,0,sel1) * mux(constant,pkt_1,sel2) + mux(pkt_2,pkt_3,sel3)` over a 3-stage pipeline with read-after-write forwarding. It accepts one packet per cycle, has no backpressure, and sits in a pipeline stage of the switch datapath alongside the other stateful atoms.

## Interface
Parameters:
- `COUNT_WIDTH`, 32: data and state width, in bits.
- `NUM_SLOTS`, 16: number of state registers. Must be ≥2.
- `IDX_WIDTH`, `$clog2(NUM_SLOTS)`: index width.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i__valid`  in  1  a packet operation is presented this cycle.
- `i__index`  in  IDX_WIDTH  state slot to operate on.
- `i__constant`, `i__pkt_1`, `i__pkt_2`, `i__pkt_3`  in  COUNT_WIDTH  operands.
- `i__sel1`, `i__sel2`, `i__sel3`  in  1  mux selects.
- `o__valid`  out  1  result valid.
- `o__index`  out  IDX_WIDTH  slot of the result.
- `o__read`  out  COUNT_WIDTH  slot value before this operation.
- `o__write`  out  COUNT_WIDTH  new slot value.

## Operation
- **S0, capture (edge E0).** All inputs are registered. `valid` becomes `i__valid`.
- **S1, read and multiply (cycle E0→E1).**
  - `old` = `state[idx]`, unless the forwarding rule below applies.
  - `a` = `sel1 ? 0 : old`; `b` = `sel2 ? pkt_1 : constant`; `c` = `sel3 ? pkt_3 : pkt_2`.
  - At E1, register `prod = a*b` (truncated to COUNT_WIDTH), plus `c`, `old`, `idx` and `valid`.
- **S2, add and write back (cycle E1→E2).**
  - `sum = prod + c`, truncated to COUNT_WIDTH.
  - At E2, if `valid`: `state[idx] <= sum`, `o__write <= sum`, `o__read <= old`, `o__index <= idx`, `o__valid <= 1`.
  - At E2, if not `valid`: `o__valid <= 0`; the data outputs hold their previous values and the state is unchanged.
- **Forwarding.** If S2 is valid and its idx equals S1's idx, S1 uses S2's combinational `sum` as `old`, not the array value. This is the only hazard: an operation two or more slots behind reads the array after the write has landed.
- Arithmetic is unsigned, modulo 2^COUNT_WIDTH, unless saturation is compiled in.
- An `i__index` ≥ NUM_SLOTS (possible only when NUM_SLOTS is not a power of 2) is treated as a bubble: no write, and `o__valid` = 0 for that slot.

## Timing
- Accepts one operation every cycle. There is no stall and no ready signal.
- Latency: inputs sampled at E0, result visible on outputs after E2 (3 rising edges, counting E0).
- Back-to-back operations on the same index must produce the same results as serial execution.
- Reset (`rst_n` = 0 at an edge):
  - all state slots = 0;
  - all pipeline valid bits = 0;
  - `o__valid` = 0, `o__index` = 0, `o__read` = 0, `o__write` = 0.
- Reset mid-operation: in-flight operations are discarded, no slot is written, and the first valid output after deassertion comes from an operation sampled after deassertion.
- Invalid cycles create bubbles. Bubbles never write and never forward.

## Configuration
- `MAC_ATOM_SATURATE_EN`:
  - **Defined:** the multiply and the add each clamp to 2^COUNT_WIDTH−1 on unsigned overflow. The S1 product is computed at 2×COUNT_WIDTH and clamped before it is registered. The add is computed at COUNT_WIDTH+1 bits and clamped.
  - **Undefined:** both the multiply and the add wrap modulo 2^COUNT_WIDTH.
  - In both cases the forwarded value equals the value written.

## Test plan
- **Reset:** after reset, op idx=3, sel1=0, sel2=0, constant=5, sel3=0, pkt_2=7 → 3 cycles later `o__valid`=1, `o__read`=0, `o__write`=7.
- **Back-to-back accumulate:** 4 consecutive ops on idx=2 with constant=2, pkt_2=1 → `o__write` sequence 1, 3, 7, 15. This exercises forwarding on every cycle.
- **Slot isolation:** alternating idx 0/1 with pkt_2 = 10 and 20, constant=1 → slot 0 outputs 10, 20, 30; slot 1 outputs 20, 40, 60.
- **Gating and mux:** sel1=1, sel3=1, pkt_3=9 on a slot holding 100 → `o__read`=100, `o__write`=9.
- **Overflow (W=32):** state 0xFFFFFFFF, constant=1, pkt_2=2 → wrapped `o__write`=1. With `MAC_ATOM_SATURATE_EN` defined → 0xFFFFFFFF.
- **Reset mid-flight:** assert `rst_n`=0 for 1 cycle while 2 ops are in flight → no `o__valid` pulse for those ops, and a following read of that slot returns `o__read`=0.
